qea_host_sequencer: RTL
=======================

Name: qea_host_sequencer

Overview:
- Host-side front end that sits directly upstream of the QEA core and drives its context-load, state-load, start and readback ports.
- Accepts one 64-bit input stream carrying gate-context words followed by initial state amplitudes, writes them into QEA's CTX and STATE RAMs, pulses start, and waits for complete.
- After completion, reads the final state vector back out of QEA and emits it as a 64-bit output stream with backpressure.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM
- PE_NUM, 4, amplitudes per STATE RAM row (lanes)
- STATE_DATA_WIDTH, 64, one complex amplitude {re[63:32], im[31:0]}, Q2.30
- STATE_ADDR_WIDTH, 16, STATE RAM row address width
- GATE_CONTEXT_DATA_WIDTH, 64, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, CTX RAM address width
- MAX_QBIT_WIDTH, 6, width of qubit-count field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_cfg_valid  in  1  one-cycle pulse that latches the job and leaves IDLE; ignored when not in IDLE
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  number of context words
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count
- s_valid / s_ready  in/out  1  input stream handshake
- s_data  in  64  context or amplitude word
- o_ctx_en, o_ctx_wea  out  1  CTX RAM write strobes
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  CTX address
- o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  CTX data
- o_state_ena, o_state_wea  out  1  STATE RAM enable / write
- o_state_addra  out  STATE_ADDR_WIDTH  STATE row address
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  STATE row write data
- o_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count to QEA
- o_start  out  1  one-cycle start pulse to QEA
- i_complete  in  1  QEA completion level
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  STATE read data, valid 1 cycle after a read strobe
- m_valid / m_ready  out/in  1  output stream handshake
- m_data  out  64  readback amplitude
- o_busy  out  1  high whenever FSM is not in IDLE
- o_err  out  1  sticky config error, cleared by the next accepted i_cfg_valid

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- ROWS = 2**(qbit_num - PE_NUM_WIDTH).
- IDLE:
  - on i_cfg_valid, latch i_ins_num and i_qbit_num.
  - if qbit_num < PE_NUM_WIDTH, or qbit_num - PE_NUM_WIDTH > STATE_ADDR_WIDTH: set o_err, stay in IDLE.
  - else if ins_num == 0, go to LOAD_STATE; otherwise go to LOAD_CTX.
- LOAD_CTX:
  - s_ready = 1.
  - each handshake writes the word the same cycle: o_ctx_en = o_ctx_wea = 1, data = s_data, addr = counter (0..ins_num-1).
  - strobes are 0 on cycles with no handshake.
  - after word ins_num-1, go to LOAD_STATE.
- LOAD_STATE:
  - s_ready = 1 while packing a row.
  - lane order: the first word of a row lands in bits [PE_NUM*64-1 -: 64] (MSB lane); the last word lands in bits [63:0].
  - when the PE_NUM-th word is accepted, the row writes on the next cycle (o_state_ena = o_state_wea = 1, addr = row counter).
  - s_ready is 0 during that write cycle.
  - after row ROWS-1 is written, go to START.
- START:
  - o_start = 1 for exactly one cycle; o_qbit_num is held stable from cfg accept until the next cfg.
  - go to RUN.
- RUN:
  - wait for i_complete == 1; an i_complete that is already high in the START cycle is ignored.
  - no timeout.
- RD_REQ: o_state_ena = 1, o_state_wea = 0, addr = row counter.
- RD_WAIT: next cycle, latch i_state_dout into the row buffer.
- RD_SEND:
  - m_valid = 1; m_data presents lanes MSB first.
  - the lane advances only on m_valid & m_ready; m_data holds stable while m_ready = 0.
  - after the last lane: next row goes to RD_REQ; after row ROWS-1, return to IDLE.
- Throughput: readback takes PE_NUM + 2 cycles per row with m_ready held high.
- s_data arriving outside LOAD_CTX/LOAD_STATE is not accepted (s_ready = 0).
- Address wrap is impossible by construction; counters are sized to the address widths.
- rst asserted mid-job:
  - immediately clears all strobes, o_start and m_valid, and returns to IDLE.
  - partially written RAM contents are left as-is.

Test Plan:
- qbit 6, ins_num 3, words C0..C2, then 64 amplitudes with word0 = 0x40000000_00000000 and the rest 0 -> CTX writes at addrs 0,1,2; 16 STATE writes; row0 dina = 0x40000000_00000000 followed by 192 zero bits; one o_start pulse.
- Same job with s_valid toggling every other cycle -> identical RAM write sequence; no write strobe on idle cycles.
- Model raises i_complete 50 cycles after start and returns rows holding 0..63 -> m_data emits 0..63 in order (lane MSB first per row); o_busy drops after the 64th beat.
- m_ready held low for 5 cycles in the middle of a row -> m_data and m_valid stay stable; no beat is lost or duplicated.
- cfg with qbit 1 -> o_err = 1, o_busy stays 0; a following valid cfg clears o_err.
- Assert rst during LOAD_STATE row 7 -> all strobes 0 on the next edge; a new cfg completes normally.

Source files
------------

// File: rtl/qea_host_sequencer_if.sv
// Host-side streaming bundle for qea_host_sequencer: inbound load stream and outbound readback stream.
interface qea_host_sequencer_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/qea_host_sequencer.sv
// Host front end for QEA: loads CTX/STATE RAMs from one input stream, starts the core,
// then streams the final state vector back out lane by lane.
module qea_host_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_cfg_valid,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  qea_host_sequencer_if.slave                bus,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
  output logic                               o_state_ena,
  output logic                               o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qbit_num,
  output logic                               o_start,
  input  logic                               i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dout,
  output logic                               o_busy,
  output logic                               o_err
);
  localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;

  typedef enum logic [3:0] {
    IDLE, LOAD_CTX, LOAD_STATE, STATE_WR, START, RUN, RD_REQ, RD_WAIT, RD_SEND
  } state_t;

  state_t                             state, state_nx;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt;
  logic [PE_NUM_WIDTH-1:0]            lane_cnt;
  logic [STATE_ADDR_WIDTH-1:0]        row_cnt;
  logic [STATE_ADDR_WIDTH-1:0]        last_row;
  logic [ROW_W-1:0]                   row_buf;
  logic                               cfg_bad;
  logic                               s_hs;
  logic                               m_hs;
  logic                               ctx_last;
  logic                               lane_last;
  logic                               row_last;

  assign cfg_bad = (i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) ||
                   ((i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH));
  // A full 2**STATE_ADDR_WIDTH row count shifts out to 0 and wraps back to all-ones.
  assign last_row  = (STATE_ADDR_WIDTH'(1) << (o_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH)))
                     - STATE_ADDR_WIDTH'(1);
  assign s_hs      = bus.s_valid && bus.s_ready;
  assign m_hs      = bus.m_valid && bus.m_ready;
  assign ctx_last  = (ctx_cnt == ins_q - GATE_CONTEXT_ADDR_WIDTH'(1));
  assign lane_last = (lane_cnt == PE_NUM_WIDTH'(PE_NUM - 1));
  assign row_last  = (row_cnt == last_row);
  assign o_busy    = (state != IDLE);

  always_comb begin
    state_nx      = state;
    bus.s_ready   = 1'b0;
    bus.m_valid   = 1'b0;
    bus.m_data    = '0;
    o_ctx_en      = 1'b0;
    o_ctx_wea     = 1'b0;
    o_ctx_addr    = '0;
    o_ctx_data    = '0;
    o_state_ena   = 1'b0;
    o_state_wea   = 1'b0;
    o_state_addra = '0;
    o_state_dina  = '0;
    o_start       = 1'b0;
    case (state)
      IDLE: begin
        if (i_cfg_valid && !cfg_bad)
          state_nx = (i_ins_num == '0) ? LOAD_STATE : LOAD_CTX;
      end
      LOAD_CTX: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          o_ctx_en   = 1'b1;
          o_ctx_wea  = 1'b1;
          o_ctx_addr = ctx_cnt;
          o_ctx_data = GATE_CONTEXT_DATA_WIDTH'(bus.s_data);
          if (ctx_last) state_nx = LOAD_STATE;
        end
      end
      LOAD_STATE: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid && lane_last) state_nx = STATE_WR;
      end
      STATE_WR: begin
        o_state_ena   = 1'b1;
        o_state_wea   = 1'b1;
        o_state_addra = row_cnt;
        o_state_dina  = row_buf;
        state_nx      = row_last ? START : LOAD_STATE;
      end
      START: begin
        o_start  = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        if (i_complete) state_nx = RD_REQ;
      end
      RD_REQ: begin
        o_state_ena   = 1'b1;
        o_state_addra = row_cnt;
        state_nx      = RD_WAIT;
      end
      RD_WAIT: state_nx = RD_SEND;
      RD_SEND: begin
        bus.m_valid = 1'b1;
        bus.m_data  = row_buf[ROW_W-1 -: STATE_DATA_WIDTH];
        if (bus.m_ready && lane_last) state_nx = row_last ? IDLE : RD_REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ins_q      <= '0;
      o_qbit_num <= '0;
      o_err      <= 1'b0;
      ctx_cnt    <= '0;
      lane_cnt   <= '0;
      row_cnt    <= '0;
      row_buf    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (i_cfg_valid) begin
            ins_q      <= i_ins_num;
            o_qbit_num <= i_qbit_num;
            o_err      <= cfg_bad;
            ctx_cnt    <= '0;
            lane_cnt   <= '0;
            row_cnt    <= '0;
          end
        end
        LOAD_CTX: begin
          if (s_hs) ctx_cnt <= ctx_last ? '0 : ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
        end
        LOAD_STATE: begin
          // First word of a row ends up in the MSB lane after PE_NUM shifts.
          if (s_hs) begin
            row_buf  <= {row_buf[ROW_W-STATE_DATA_WIDTH-1:0], STATE_DATA_WIDTH'(bus.s_data)};
            lane_cnt <= lane_cnt + PE_NUM_WIDTH'(1);
          end
        end
        STATE_WR: row_cnt <= row_last ? '0 : row_cnt + STATE_ADDR_WIDTH'(1);
        RD_WAIT: begin
          row_buf  <= i_state_dout;
          lane_cnt <= '0;
        end
        RD_SEND: begin
          if (m_hs) begin
            row_buf  <= {row_buf[ROW_W-STATE_DATA_WIDTH-1:0], STATE_DATA_WIDTH'(0)};
            lane_cnt <= lane_cnt + PE_NUM_WIDTH'(1);
            if (lane_last) row_cnt <= row_last ? '0 : row_cnt + STATE_ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
